// File: rtl/system_0_sysid_pkg.sv
// ---------------------------------------------------------------------------
// system_0_sysid_pkg
// Shared definitions for the system ID checker.
// The package holds the FSM state encoding and the word addresses of the
// sysid slave. It also holds a helper that sizes counters from their
// maximum value.
// ---------------------------------------------------------------------------
package system_0_sysid_pkg;

    // Checker sequence states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ID   = 3'd1,
        ST_WAIT_ID = 3'd2,
        ST_RD_TS   = 3'd3,
        ST_WAIT_TS = 3'd4,
        ST_FINISH  = 3'd5
    } sysid_state_e;

    // Word addresses inside the sysid slave
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int SYSID_DATA_W = 32;

    // Bits needed to hold max_value, never fewer than min_width
    function automatic int cnt_width(input int max_value, input int min_width);
        int w;
        w = $clog2(max_value + 1);
        return (w < min_width) ? min_width : w;
    endfunction

endpackage : system_0_sysid_pkg

// File: rtl/system_0_sysid_timer.sv
// ---------------------------------------------------------------------------
// system_0_sysid_timer
// Loadable per-read timeout counter.
// i_load clears the count. While i_en is high the count advances by one per
// cycle. o_expired is a registered flag. It is high during the LIMIT-th
// enabled cycle after a load, which is the last cycle a read may use.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   i_load         : restart the count at zero (wins over i_en)
//   i_en           : count this cycle
//   o_expired      : budget used up; the owner aborts on this cycle's edge
// ---------------------------------------------------------------------------
module system_0_sysid_timer
    import system_0_sysid_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_expired;

    // Count register with a pre-decoded expiry flag; saturates at LAST
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= '0;
            r_expired <= 1'b0;
        end else if (i_load) begin
            r_count   <= '0;
            r_expired <= (LAST == '0);
        end else if (i_en && (r_count != LAST)) begin
            r_count   <= r_count + ONE;
            r_expired <= ((r_count + ONE) == LAST);
        end else begin
            r_count   <= r_count;
            r_expired <= r_expired;
        end
    end

    assign o_expired = r_expired;

endmodule : system_0_sysid_timer

// File: rtl/system_0_sysid_checker.sv
// ---------------------------------------------------------------------------
// system_0_sysid_checker
// Avalon-MM master that reads the sysid slave (ID word at address 0, then the
// timestamp word at address 1). It compares both words with build-time
// constants and reports the result. Each read has a timeout. After a timeout
// the whole sequence is retried, up to MAX_RETRIES times.
// Ports:
//   clock, reset_n      : clock, asynchronous active-low reset
//   start               : pulse to begin a sequence (ignored while busy)
//   avm_address/read    : read request to the sysid slave
//   avm_waitrequest     : slave stall
//   avm_readdatavalid   : response strobe, avm_readdata holds the response word
//   busy, done          : sequence active / one-cycle end-of-sequence pulse
//   id_ok, ts_ok        : comparison results, held until the next start
//   timeout             : retries exhausted
//   id_value, ts_value  : last captured words
// ---------------------------------------------------------------------------
module system_0_sysid_checker
    import system_0_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          MAX_RETRIES        = 3,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    avm_address,
    output logic                    avm_read,
    input  logic                    avm_waitrequest,
    input  logic                    avm_readdatavalid,
    input  logic [SYSID_DATA_W-1:0] avm_readdata,
    output logic                    busy,
    output logic                    done,
    output logic                    id_ok,
    output logic                    ts_ok,
    output logic                    timeout,
    output logic [SYSID_DATA_W-1:0] id_value,
    output logic [SYSID_DATA_W-1:0] ts_value
);

    localparam int TW = cnt_width(TIMEOUT_CYCLES, 8);
    localparam int RW = cnt_width(MAX_RETRIES, 1);
    localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRIES);
    localparam logic [RW-1:0] ONE_R = RW'(1);

    sysid_state_e r_state;
    sysid_state_e w_next_state;

    logic          r_outstanding;
    logic          r_auto_pending;
    logic [RW-1:0] r_retries;

    logic r_avm_read;
    logic r_avm_address;
    logic r_busy;
    logic r_done;
    logic r_id_ok;
    logic r_ts_ok;
    logic r_timeout;
    logic [SYSID_DATA_W-1:0] r_id_value;
    logic [SYSID_DATA_W-1:0] r_ts_value;

    logic w_in_rd;
    logic w_in_wait;
    logic w_in_read;
    logic w_accept;
    logic w_rdv_fresh;
    logic w_start_req;
    logic w_begin;
    logic w_timer_expired;
    logic w_timer_load;
    logic w_abort;
    logic w_capture_id;
    logic w_capture_ts;
    logic w_capture_any;
    logic w_can_retry;
    logic w_retry;
    logic w_give_up;
    logic w_set_out;

    logic w_read_nx;
    logic w_addr_nx;
    logic w_busy_nx;
    logic w_done_nx;

    // ---- decode of the current cycle ------------------------------------
    assign w_in_rd   = (r_state == ST_RD_ID)   || (r_state == ST_RD_TS);
    assign w_in_wait = (r_state == ST_WAIT_ID) || (r_state == ST_WAIT_TS);
    assign w_in_read = w_in_rd || w_in_wait;
    assign w_accept  = w_in_rd && !avm_waitrequest;

    // A response that arrives while a stale request is still owed belongs to
    // that aborted request and must never be captured.
    assign w_rdv_fresh = avm_readdatavalid && !r_outstanding;

    assign w_start_req = start || r_auto_pending;
    assign w_begin     = (r_state == ST_IDLE) && w_start_req;

    // Zero-latency responses are captured in the acceptance cycle itself
    assign w_capture_id = w_rdv_fresh &&
                          (((r_state == ST_RD_ID) && w_accept) || (r_state == ST_WAIT_ID));
    assign w_capture_ts = w_rdv_fresh &&
                          (((r_state == ST_RD_TS) && w_accept) || (r_state == ST_WAIT_TS));
    assign w_capture_any = w_capture_id || w_capture_ts;

    // A response arriving on the expiry cycle is still accepted
    assign w_abort     = w_in_read && w_timer_expired && !w_capture_any;
    assign w_can_retry = (r_retries < MAX_R);
    assign w_retry     = w_abort && w_can_retry;
    assign w_give_up   = w_abort && !w_can_retry;

    // Aborting after the slave took the request leaves one response in flight
    assign w_set_out = w_abort && (w_in_wait || w_accept);

    // A retry from RD_ID back into RD_ID also restarts the budget
    assign w_timer_load = ((w_next_state == ST_RD_ID) || (w_next_state == ST_RD_TS)) &&
                          ((w_next_state != r_state) || w_retry);

    system_0_sysid_timer #(
        .WIDTH (TW),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_load    (w_timer_load),
        .i_en      (w_in_read),
        .o_expired (w_timer_expired)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_req) w_next_state = ST_RD_ID;
                else             w_next_state = ST_IDLE;
            end
            ST_RD_ID: begin
                if (w_capture_id)   w_next_state = ST_RD_TS;
                else if (w_retry)   w_next_state = ST_RD_ID;
                else if (w_give_up) w_next_state = ST_FINISH;
                else if (w_accept)  w_next_state = ST_WAIT_ID;
                else                w_next_state = ST_RD_ID;
            end
            ST_WAIT_ID: begin
                if (w_capture_id)   w_next_state = ST_RD_TS;
                else if (w_retry)   w_next_state = ST_RD_ID;
                else if (w_give_up) w_next_state = ST_FINISH;
                else                w_next_state = ST_WAIT_ID;
            end
            ST_RD_TS: begin
                if (w_capture_ts)   w_next_state = ST_FINISH;
                else if (w_retry)   w_next_state = ST_RD_ID;
                else if (w_give_up) w_next_state = ST_FINISH;
                else if (w_accept)  w_next_state = ST_WAIT_TS;
                else                w_next_state = ST_RD_TS;
            end
            ST_WAIT_TS: begin
                if (w_capture_ts)   w_next_state = ST_FINISH;
                else if (w_retry)   w_next_state = ST_RD_ID;
                else if (w_give_up) w_next_state = ST_FINISH;
                else                w_next_state = ST_WAIT_TS;
            end
            ST_FINISH: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM outputs for the upcoming state (registered below)
    always_comb begin
        w_read_nx = 1'b0;
        w_addr_nx = SYSID_ADDR_ID;
        w_busy_nx = 1'b0;
        w_done_nx = 1'b0;
        case (w_next_state)
            ST_IDLE: begin
                w_busy_nx = 1'b0;
            end
            ST_RD_ID: begin
                w_read_nx = 1'b1;
                w_busy_nx = 1'b1;
            end
            ST_WAIT_ID: begin
                w_busy_nx = 1'b1;
            end
            ST_RD_TS: begin
                w_read_nx = 1'b1;
                w_addr_nx = SYSID_ADDR_TS;
                w_busy_nx = 1'b1;
            end
            ST_WAIT_TS: begin
                w_addr_nx = SYSID_ADDR_TS;
                w_busy_nx = 1'b1;
            end
            ST_FINISH: begin
                w_busy_nx = 1'b1;
                w_done_nx = 1'b1;
            end
            default: begin
                w_busy_nx = 1'b0;
            end
        endcase
    end

    // Output registers for the bus request and the busy/done status
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_avm_read    <= 1'b0;
            r_avm_address <= SYSID_ADDR_ID;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_avm_read    <= w_read_nx;
            r_avm_address <= w_addr_nx;
            r_busy        <= w_busy_nx;
            r_done        <= w_done_nx;
        end
    end

    // One-shot start request for the first cycle after reset release
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_auto_pending <= AUTO_START;
        end else begin
            r_auto_pending <= 1'b0;
        end
    end

    // Retry counter: cleared at sequence start, bumped on every retry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_retries <= '0;
        end else if (w_begin) begin
            r_retries <= '0;
        end else if (w_retry) begin
            r_retries <= r_retries + ONE_R;
        end else begin
            r_retries <= r_retries;
        end
    end

    // Stale-response flag: set by an abort with a request in flight; the next
    // response of any kind consumes it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_outstanding <= 1'b0;
        end else if (w_set_out) begin
            r_outstanding <= 1'b1;
        end else if (avm_readdatavalid) begin
            r_outstanding <= 1'b0;
        end else begin
            r_outstanding <= r_outstanding;
        end
    end

    // Captured words: updated only by accepted, fresh responses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_id_value <= '0;
            r_ts_value <= '0;
        end else begin
            if (w_capture_id) r_id_value <= avm_readdata;
            else              r_id_value <= r_id_value;
            if (w_capture_ts) r_ts_value <= avm_readdata;
            else              r_ts_value <= r_ts_value;
        end
    end

    // Result flags: cleared at start, forced on give-up, else follow the compare
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_id_ok   <= 1'b0;
            r_ts_ok   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_begin || w_give_up) r_id_ok <= 1'b0;
            else if (w_capture_id)    r_id_ok <= (avm_readdata == EXPECTED_ID);
            else                      r_id_ok <= r_id_ok;

            if (w_begin || w_give_up) r_ts_ok <= 1'b0;
            else if (w_capture_ts)    r_ts_ok <= (avm_readdata == EXPECTED_TIMESTAMP);
            else                      r_ts_ok <= r_ts_ok;

            if (w_begin)        r_timeout <= 1'b0;
            else if (w_give_up) r_timeout <= 1'b1;
            else                r_timeout <= r_timeout;
        end
    end

    assign avm_read    = r_avm_read;
    assign avm_address = r_avm_address;
    assign busy        = r_busy;
    assign done        = r_done;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout     = r_timeout;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule : system_0_sysid_checker

// File: tb/tb_system_0_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_system_0_sysid_checker
// Directed bench for the sysid checker. The bench contains a behavioural
// sysid slave, and each scenario configures it. Expected results are queued
// when a sequence is launched and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_system_0_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'hA5A5_0001;
    localparam logic [31:0] EXP_TS = 32'h6123_4567;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    system_0_sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (255),
        .MAX_RETRIES        (3),
        .AUTO_START         (1'b1)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_readdata      (avm_readdata),
        .busy              (busy),
        .done              (done),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .timeout           (timeout),
        .id_value          (id_value),
        .ts_value          (ts_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---- sysid slave model configuration (written by the stimulus only) --
    int cfg_wait       = 0;
    int cfg_lat        = 1;
    bit cfg_noresp     = 1'b0;
    bit cfg_tscorrupt  = 1'b0;
    bit cfg_firstdelay = 1'b0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t rq[$];
    int    wait_cnt   = 0;
    logic  held_addr  = 1'b0;
    int    stall_viol = 0;
    int    acc_cnt    = 0;
    int    last_due   = -1;
    bit    first_done = 1'b0;

    // Slave model: decides waitrequest and responses for the current cycle
    always @(negedge clock) begin
        resp_t r;
        if (!reset_n) begin
            avm_waitrequest   = 1'b0;
            avm_readdatavalid = 1'b0;
            avm_readdata      = 32'h0;
            wait_cnt          = 0;
            last_due          = -1;
            first_done        = 1'b0;
            rq.delete();
        end else begin
            avm_waitrequest = 1'b0;
            if (avm_read) begin
                if (wait_cnt > 0 && avm_address !== held_addr) stall_viol++;
                if (wait_cnt < cfg_wait) begin
                    if (wait_cnt == 0) held_addr = avm_address;
                    avm_waitrequest = 1'b1;
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    acc_cnt++;
                    if (!cfg_noresp) begin
                        r.data = avm_address ? (cfg_tscorrupt ? (EXP_TS ^ 32'h0000_0001) : EXP_TS)
                                             : EXP_ID;
                        r.due  = cyc + cfg_lat;
                        if (cfg_firstdelay && !first_done) begin
                            r.data     = 32'hDEAD_BEEF;
                            r.due      = cyc + 300;
                            first_done = 1'b1;
                        end
                        if (r.due <= last_due) r.due = last_due + 1;
                        last_due = r.due;
                        rq.push_back(r);
                    end
                end
            end else begin
                if (wait_cnt > 0) stall_viol++;
                wait_cnt = 0;
            end
            avm_readdatavalid = 1'b0;
            avm_readdata      = 32'h0;
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = rq[0].data;
                void'(rq.pop_front());
            end
        end
    end

    // ---- scoreboard -------------------------------------------------------
    typedef struct {
        int          lat;
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        logic [31:0] id_v;
        logic [31:0] ts_v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input int lat, input logic iok, input logic tok, input logic tmo,
                            input logic [31:0] idv, input logic [31:0] tsv);
        exp_t e;
        e.lat = lat; e.id_ok = iok; e.ts_ok = tok; e.tmo = tmo; e.id_v = idv; e.ts_v = tsv;
        exp_q.push_back(e);
    endtask

    // Counts cycles from the start edge until done; may pulse start at pulse_at
    task automatic wait_done(input string tag, input int n0, input int pulse_at, output int n);
        bit got;
        got = 1'b0;
        n   = n0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            n++;
            start = (n == pulse_at);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 96'(got), 96'(1'b1));
    endtask

    task automatic check_result(input string tag, input int n);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 96'(exp_q.size()), 96'(1));
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_latency"},  96'(n),        96'(e.lat));
            chk({tag, "_id_ok"},    96'(id_ok),    96'(e.id_ok));
            chk({tag, "_ts_ok"},    96'(ts_ok),    96'(e.ts_ok));
            chk({tag, "_timeout"},  96'(timeout),  96'(e.tmo));
            chk({tag, "_id_value"}, 96'(id_value), 96'(e.id_v));
            chk({tag, "_ts_value"}, 96'(ts_value), 96'(e.ts_v));
            @(negedge clock);
            chk({tag, "_done_pulse_busy"}, 96'({done, busy}), 96'(2'b00));
        end
    endtask

    task automatic check_idle_for(input string tag, input int cycles);
        int extra;
        extra = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            if (busy !== 1'b0 || done !== 1'b0 || avm_read !== 1'b0) extra++;
        end
        chk({tag, "_no_second_seq"}, 96'(extra), 96'(0));
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    function automatic logic [95:0] all_outputs();
        return {25'h0, busy, done, id_ok, ts_ok, timeout, avm_read, avm_address, id_value, ts_value};
    endfunction

    // ---- directed stimulus ------------------------------------------------
    initial begin
        int n;
        int acc0;
        bit found;

        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", all_outputs(), 96'h0);

        // 1: matching words, 1-cycle response, auto start; extra start while busy
        push_exp(5, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
        reset_n = 1'b1;
        wait_done("t1", 0, 2, n);
        check_result("t1", n);
        check_idle_for("t1", 10);

        // 2: explicit start, corrupted timestamp; flags clear on start
        cfg_tscorrupt = 1'b1;
        push_exp(5, 1'b1, 1'b0, 1'b0, EXP_ID, EXP_TS ^ 32'h0000_0001);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("t2_flags_cleared", 96'({id_ok, ts_ok, timeout, busy}), 96'(4'b0001));
        wait_done("t2", 1, 0, n);
        check_result("t2", n);
        cfg_tscorrupt = 1'b0;

        // 3: waitrequest held 10 cycles on each read
        apply_reset();
        cfg_wait = 10;
        acc0 = stall_viol;
        push_exp(25, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
        reset_n = 1'b1;
        wait_done("t3", 0, 0, n);
        check_result("t3", n);
        chk("t3_stall_stable", 96'(stall_viol - acc0), 96'(0));
        cfg_wait = 0;

        // 4: no response ever: 4 attempts of 255 cycles, then timeout
        apply_reset();
        cfg_noresp = 1'b1;
        acc0 = acc_cnt;
        push_exp(1 + 4 * 255, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        reset_n = 1'b1;
        wait_done("t4", 0, 0, n);
        check_result("t4", n);
        chk("t4_attempts", 96'(acc_cnt - acc0), 96'(4));
        cfg_noresp = 1'b0;

        // 5: first response 300 cycles late with garbage; must be dropped
        apply_reset();
        cfg_firstdelay = 1'b1;
        push_exp(305, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
        reset_n = 1'b1;
        wait_done("t5", 0, 0, n);
        check_result("t5", n);
        cfg_firstdelay = 1'b0;

        // 5b: zero-latency responses skip both WAIT states
        apply_reset();
        cfg_lat = 0;
        push_exp(3, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
        reset_n = 1'b1;
        wait_done("t5b", 0, 0, n);
        check_result("t5b", n);
        cfg_lat = 1;

        // 6: start pulsed while busy, then reset in WAIT_TS
        apply_reset();
        cfg_lat = 20;
        reset_n = 1'b1;
        found = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            start = (k == 2);
            if (busy === 1'b1 && avm_read === 1'b0 && avm_address === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk("t6_reached_wait_ts", 96'(found), 96'(1'b1));
        reset_n = 1'b0;
        #1;
        chk("t6_reset_outputs", all_outputs(), 96'h0);
        repeat (2) @(negedge clock);
        cfg_lat = 1;
        push_exp(5, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS);
        reset_n = 1'b1;
        wait_done("t6", 0, 0, n);
        check_result("t6", n);
        check_idle_for("t6", 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_system_0_sysid_checker
